// File: rtl/seq_div.sv
// seq_div: 32-bit signed restoring divider, one quotient bit per clock, truncating quotient.
// Optional macro SEQ_DIV_ZERO_CHECK_EN adds a 1-clock zero-divisor shortcut and the div_zero flag.
module seq_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             done,
    output logic             additionalOut
`ifdef SEQ_DIV_ZERO_CHECK_EN
    ,
    output logic             div_zero
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] part_q, part_d;   // partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;     // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic [WIDTH-1:0] in1_q, in1_d;
    logic [WIDTH-1:0] in2_q, in2_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
`ifdef SEQ_DIV_ZERO_CHECK_EN
    logic             dz_q, dz_d;
`endif

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        out_d   = out_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
`ifdef SEQ_DIV_ZERO_CHECK_EN
        dz_d    = dz_q;
`endif
        shifted = {part_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};

        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef SEQ_DIV_ZERO_CHECK_EN
                    if (in2 == '0) begin
                        out_d  = '1;
                        rem_d  = in1;
                        ovf_d  = 1'b0;
                        dz_d   = 1'b1;
                        done_d = 1'b1;
                    end else
`endif
                    begin
                        s1_d    = in1[WIDTH-1];
                        s2_d    = in2[WIDTH-1];
                        in1_d   = in1;
                        in2_d   = in2;
                        // -MIN wraps to MIN, which is the correct unsigned magnitude.
                        quo_d   = in1[WIDTH-1] ? -in1 : in1;
                        dvs_d   = in2[WIDTH-1] ? -in2 : in2;
                        part_d  = '0;
                        cnt_d   = CW'(WIDTH);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (!diff[WIDTH]) begin
                    part_d = diff[WIDTH-1:0];
                    quo_d  = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    part_d = shifted[WIDTH-1:0];
                    quo_d  = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_d == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                out_d   = (s1_q ^ s2_q) ? -quo_q : quo_q;
                rem_d   = s1_q ? -part_q : part_q;
                ovf_d   = (in1_q == MIN_VAL) && (in2_q == '1);
`ifdef SEQ_DIV_ZERO_CHECK_EN
                dz_d    = 1'b0;
`endif
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            part_q  <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            in1_q   <= '0;
            in2_q   <= '0;
            out_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SEQ_DIV_ZERO_CHECK_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
`ifdef SEQ_DIV_ZERO_CHECK_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign out           = out_q;
    assign rem           = rem_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign additionalOut = ovf_q;
`ifdef SEQ_DIV_ZERO_CHECK_EN
    assign div_zero      = dz_q;
`endif

endmodule

// File: tb/tb_seq_div.sv
// Scoreboard bench for seq_div: driver pushes model results, monitor pops and compares on done.
module tb_seq_div;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic [W-1:0] out;
    logic [W-1:0] rem;
    logic         busy;
    logic         done;
    logic         ovf;
`ifdef SEQ_DIV_ZERO_CHECK_EN
    logic         dz;
`endif

    always #5 clk = ~clk;

    seq_div #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in1           (in1),
        .in2           (in2),
        .out           (out),
        .rem           (rem),
        .busy          (busy),
        .done          (done),
        .additionalOut (ovf)
`ifdef SEQ_DIV_ZERO_CHECK_EN
        ,
        .div_zero      (dz)
`endif
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         ovf;
        logic         dz;
        int           lat;  // edges from the accepting edge to the edge that raises done
        int           acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sbv, q, r;
        sa    = longint'($signed(a));
        sbv   = longint'($signed(b));
        e.ovf = 1'b0;
        e.dz  = 1'b0;
        e.lat = 33;
        e.acc = 0;
        if (b == '0) begin
`ifdef SEQ_DIV_ZERO_CHECK_EN
            e.q   = '1;
            e.r   = a;
            e.dz  = 1'b1;
            e.lat = 0;
`else
            e.q = a[W-1] ? W'(1) : '1;
            e.r = a;
`endif
        end else begin
            q     = sa / sbv;
            r     = sa % sbv;
            e.q   = q[W-1:0];
            e.r   = r[W-1:0];
            e.ovf = (q > ((longint'(1) <<< (W-1)) - 1));
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            check("done_busy_exclusive", busy, 1'b0);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_done: got done=1 out=%0h rem=%0h, expected no done", out, rem);
            end else begin
                mon_e = sb.pop_front();
                check("quotient", out, mon_e.q);
                check("remainder", rem, mon_e.r);
                check("overflow_flag", ovf, mon_e.ovf);
`ifdef SEQ_DIV_ZERO_CHECK_EN
                check("div_zero_flag", dz, mon_e.dz);
`endif
                check("latency", cyc - mon_e.acc, mon_e.lat);
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_it);
        exp_t e;
        int   k = 0;
        @(negedge clk);
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: got busy=1, expected busy=0 within 200 cycles");
        end
        in1   = a;
        in2   = b;
        start = 1'b1;
        if (expect_it) begin
            e     = model(a, b);
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out"}, out, '0);
        check({tag, "_rem"}, rem, '0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_ovf"}, ovf, 1'b0);
`ifdef SEQ_DIV_ZERO_CHECK_EN
        check({tag, "_dz"}, dz, 1'b0);
`endif
    endtask

    initial begin
        logic [W-1:0] a, b;
        int           k;

        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        issue(-32'sd15, -32'sd3, 1'b1);
        issue(32'sd7, -32'sd2, 1'b1);
        issue(-32'sd7, 32'sd2, 1'b1);
        issue(32'h0003_5AAB, 32'd1, 1'b1);
        issue(32'd5, 32'd9, 1'b1);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        issue(-32'sd5, 32'd0, 1'b1);
        issue(32'd100, 32'd7, 1'b1);

        // Reset mid-CALC: nothing may complete from the aborted operation.
        issue(32'd40, 32'd6, 1'b0);
        repeat (9) @(posedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check_all_zero("after_reset");

        // Restart, with a second start pulsed while busy that must be ignored.
        issue(32'd40, 32'd6, 1'b1);
        repeat (5) @(negedge clk);
        in1   = 32'd100;
        in2   = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: begin
                    b = W'($urandom_range(1, 15));
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                1: b = '0;
                2: begin
                    a = 32'h8000_0000;
                    if ($urandom_range(0, 1) == 1) b = '1;
                end
                3: a = W'($urandom_range(0, 1000));
                default: ;
            endcase
            issue(a, b, 1'b1);
        end

        k = 0;
        while (sb.size() != 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_div.md
# seq_div

Sequential 32-bit signed integer divider: the inverse of the team's multiplier, and the companion datapath block on the same arithmetic chip. It accepts a dividend/divisor pair with a start pulse and iterates a radix-2 restoring division one quotient bit per clock. It then returns a truncated quotient and remainder with a one-cycle done pulse. It sits beside the multiplier and shares its operand/result port naming, so chip-level muxing treats both uniformly.

## Interface
- `WIDTH`, 32: operand and result width in bits; the counter is sized `$clog2(WIDTH)+1`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `in1`  in  WIDTH  dividend, two's complement.
- `in2`  in  WIDTH  divisor, two's complement.
- `out`  out  WIDTH  quotient, truncated toward zero.
- `rem`  out  WIDTH  remainder; its sign follows the dividend.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; `out`/`rem` are valid from this cycle until the next accepted start.
- `additionalOut`  out  1  overflow flag (`-2^(WIDTH-1) / -1`); valid alongside `done`.
- `div_zero`  out  1  divisor was zero; valid alongside `done`. Present only with `SEQ_DIV_ZERO_CHECK_EN`.

## Operation
- States are IDLE, CALC, FIX.
- IDLE:
  - On `start`=1, register the signs `s1=in1[MSB]`, `s2=in2[MSB]` and the magnitudes `|in1|`, `|in2|`.
  - Clear the partial remainder, set counter=WIDTH, then go to CALC.
- CALC, each cycle:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial-subtract the divisor magnitude using a WIDTH+1-bit subtract.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter; at 0, go to FIX.
- FIX:
  - `out` = `s1^s2` ? −q : q.
  - `rem` = `s1` ? −r : r.
  - `done`=1 and `additionalOut` = (in1 == 100…0 && in2 == all ones). Both operands are kept registered for this check.
  - Return to IDLE.
- Magnitude of `-2^(WIDTH-1)` is taken as an unsigned WIDTH-bit value (0x80000000), which is correct unsigned.
- Overflow case: `out`=0x80000000, `rem`=0, `additionalOut`=1.
- `start` while `busy`=1 is ignored. No queueing.
- `in1`/`in2` are only sampled at acceptance and may change afterwards.

## Timing
- Reset values: `out`=0, `rem`=0, `busy`=0, `done`=0, `additionalOut`=0, `div_zero`=0, state=IDLE, counter=0.
- Start accepted at edge E0, then `busy`=1.
- Iterations occur at E1..E32.
- FIX occurs at E33: `out`/`rem`/flags are registered, `done`=1 for the cycle after E33, and `busy`=0 after E33.
- Latency is 33 clocks from the accepting edge to `done`. The earliest next accept is E34 (the edge on which `done` is high).
- `done` and `busy` are never both 1.
- `rst` low at any point, including mid-CALC, immediately returns every register to its reset value. The in-flight result is discarded and no `done` is issued.

## Configuration
- `SEQ_DIV_ZERO_CHECK_EN` defined:
  - At E0 with `in2`=0, skip CALC.
  - Register `out`=0xFFFFFFFF, `rem`=`in1`, `div_zero`=1, `done`=1 in the following cycle, with `busy` staying 0. Latency is 1 clock.
  - `div_zero`=0 for all other operations.
- Not defined:
  - The `div_zero` port is absent.
  - A zero divisor runs the full 33 cycles and yields the deterministic algorithm result: `out` = `in1[MSB]` ? 1 : 0xFFFFFFFF, `rem`=`in1`, `additionalOut`=0.

## Test plan
- `in1`=−15, `in2`=−3, start → `done` exactly 33 clocks later with `out`=5, `rem`=0, `additionalOut`=0.
- `in1`=7, `in2`=−2 → `out`=−3, `rem`=1. Then `in1`=−7, `in2`=2 → `out`=−3, `rem`=−1. Both use back-to-back starts issued on the `done` cycle.
- `in1`=0x0003_5AAB, `in2`=1 → `out`=0x0003_5AAB, `rem`=0. Then `in1`=5, `in2`=9 → `out`=0, `rem`=5.
- `in1`=0x8000_0000, `in2`=0xFFFF_FFFF → `out`=0x8000_0000, `rem`=0, `additionalOut`=1.
- `in1`=−5, `in2`=0:
  - With the macro: `done` 1 clock after start, `out`=0xFFFFFFFF, `rem`=−5, `div_zero`=1.
  - Without: `done` after 33 clocks, `out`=1, `rem`=−5.
- Start 40/6; assert `rst` low at iteration 10; release → all outputs 0, no `done`. Restart with 40/6 → `out`=6, `rem`=4. A second `start` pulsed mid-operation is ignored.
